// File: rtl/pipe_skid_reg_pkg.sv
// Shared constants and helpers for the pipe_skid_reg register chain.
package pipe_skid_reg_pkg;

  // Width of the occupancy counter: it must represent 0..2*depth entries.
  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipe_skid_reg_skid.sv
// One pipeline stage: main register M feeding downstream, skid register S
// absorbing the beat that arrives in the cycle downstream stalls.
module skid_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             m_valid;
  logic             s_valid;
  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] s_data;

  // Ready depends only on the skid flop, never on out_ready.
  assign in_ready  = !s_valid;
  assign out_valid = m_valid;
  assign out_data  = m_data;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= RESET_VAL;
      s_data  <= RESET_VAL;
    end else if (out_ready || !m_valid) begin
      // M is free this edge: refill from S first, else from the input.
      // While S is full in_ready is low, so no new beat can arrive here.
      if (s_valid) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        s_valid <= 1'b0;
      end else begin
        m_valid <= in_valid;
        if (in_valid) begin
          m_data <= in_data;
        end
      end
    end else if (in_valid && !s_valid) begin
      s_valid <= 1'b1;
      s_data  <= in_data;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register chain of DEPTH skid stages with flush and a
// registered occupancy count.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_skid_reg: DEPTH must be at least 1");
  end

  logic             valid [0:DEPTH];
  logic             ready [0:DEPTH];
  logic [WIDTH-1:0] data  [0:DEPTH];
  logic             in_fire;
  logic             out_fire;
  logic [OCC_W-1:0] occ;

  assign valid[0]     = in_valid;
  assign data[0]      = in_data;
  assign ready[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    skid_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (valid[i]),
      .in_ready  (ready[i]),
      .in_data   (data[i]),
      .out_valid (valid[i+1]),
      .out_ready (ready[i+1]),
      .out_data  (data[i+1])
    );
  end

  // Refuse input while reset or flush is being applied so nothing offered
  // in those cycles is counted as transferred.
  assign in_ready  = ready[0] && !reset && !flush;
  assign out_valid = valid[DEPTH];
  assign out_data  = data[DEPTH];
  assign occupancy = occ;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = valid[DEPTH] && out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occ <= '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomised and directed bench for pipe_skid_reg against a FIFO-queue model.
module tb_pipe_skid_reg;

  localparam logic [31:0] RV2 = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [2:0]  occupancy;

  logic        in_valid3, in_ready3, out_valid3, out_ready3;
  logic [31:0] in_data3, out_data3;
  logic [2:0]  occupancy3;

  pipe_skid_reg #(.WIDTH(32), .DEPTH(2), .RESET_VAL(RV2)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_skid_reg #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'h0)) u_dut3 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .occupancy(occupancy3)
  );

  int unsigned n_pass = 0;
  int unsigned n_checks = 0;
  int unsigned acc_count = 0;
  int unsigned marker_seen = 0;
  logic [31:0] marker = 32'hF1A5_F1A5;
  logic [31:0] q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // One clock of the DEPTH=2 instance; the queue holds every accepted,
  // not-yet-delivered beat in order.
  task automatic step();
    logic        fin, fout;
    logic [31:0] din, dout, expv;
    @(negedge clk);
    fin  = in_valid && in_ready;
    fout = out_valid && out_ready && !flush && !reset;
    din  = in_data;
    dout = out_data;
    if (flush) check_eq("flush_in_ready", 32'(in_ready), 32'd0);
    if (!reset && !flush) begin
      if (q.size() == 0) check_eq("in_ready_empty", 32'(in_ready), 32'd1);
      if (q.size() == 4) check_eq("in_ready_full", 32'(in_ready), 32'd0);
      if (q.size() == 0) check_eq("out_valid_empty", 32'(out_valid), 32'd0);
    end
    if (fout) begin
      expv = (q.size() > 0) ? q.pop_front() : ~dout;
      check_eq("out_data", dout, expv);
      if (dout == marker) marker_seen++;
    end
    @(posedge clk);
    if (reset || flush) q.delete();
    else if (fin) begin
      q.push_back(din);
      acc_count++;
    end
    #1;
    check_eq("occupancy", 32'(occupancy), 32'(q.size()));
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    check_eq("drained", 32'(q.size()), 32'd0);
    check_eq("drained_occ", 32'(occupancy), 32'd0);
  endtask

  task automatic fill(input int unsigned n, input logic [31:0] base);
    out_ready = 1'b0;
    acc_count = 0;
    for (int i = 0; i < 12 && acc_count < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + acc_count;
      step();
    end
    in_valid = 1'b0;
    check_eq("fill_count", acc_count, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          edge_n;
    int          nxt;
    int          ready_at;
    logic        fi, fo;
    logic [31:0] do3;
    int          acc_edge[$];
    int          out_edge[$];
    logic [31:0] outs[$];

    // Reset with input offered: nothing accepted, outputs at reset state.
    reset = 1'b1; flush = 1'b0;
    in_valid = 1'b1; in_data = 32'h1234_5678; out_ready = 1'b0;
    in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_occupancy", 32'(occupancy), 32'd0);
      check_eq("rst_out_data", out_data, RV2);
    end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("post_rst_in_ready3", 32'(in_ready3), 32'd1);

    // DEPTH=3 back-to-back stream of 0x1..0x10.
    edge_n = 0; nxt = 1;
    for (int c = 0; c < 30; c++) begin
      in_valid3 = (nxt <= 16);
      in_data3  = 32'(nxt);
      @(negedge clk);
      fi  = in_valid3 && in_ready3;
      fo  = out_valid3 && out_ready3;
      do3 = out_data3;
      @(posedge clk);
      edge_n++;
      if (fi) begin acc_edge.push_back(edge_n); nxt++; end
      if (fo) begin out_edge.push_back(edge_n); outs.push_back(do3); end
      #1;
      if (fi && acc_edge.size() >= 3)
        check_eq("stream_occupancy", 32'(occupancy3), 32'd3);
    end
    in_valid3 = 1'b0;
    check_eq("stream_count", 32'(outs.size()), 32'd16);
    foreach (outs[i]) check_eq("stream_data", outs[i], 32'(i + 1));
    if (outs.size() > 0 && acc_edge.size() > 0)
      check_eq("stream_latency", 32'(out_edge[0] - acc_edge[0]), 32'd3);
    if (outs.size() == 16)
      check_eq("stream_out_rate", 32'(out_edge[15] - out_edge[0]), 32'd15);
    if (acc_edge.size() == 16)
      check_eq("stream_in_rate", 32'(acc_edge[15] - acc_edge[0]), 32'd15);
    check_eq("stream_final_occ", 32'(occupancy3), 32'd0);

    // Back-pressure on DEPTH=2: exactly 2*DEPTH beats stored.
    out_ready = 1'b0;
    acc_count = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h3000 + acc_count;
      step();
    end
    in_valid = 1'b0;
    check_eq("bp_accepted", acc_count, 32'd4);
    check_eq("bp_occupancy", 32'(occupancy), 32'd4);
    check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    ready_at = -1;
    for (int i = 1; i <= 10 && q.size() > 0; i++) begin
      step();
      if (ready_at < 0 && in_ready) ready_at = i;
    end
    check_eq("bp_ready_back", 32'(ready_at >= 1 && ready_at <= 2), 32'd1);
    check_eq("bp_drained", 32'(q.size()), 32'd0);

    // Random valid/ready against the queue model, with varying back-pressure.
    for (int blk = 0; blk < 10; blk++) begin
      int unsigned pr;
      pr = $urandom_range(1, 9);
      for (int i = 0; i < 1000; i++) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        in_data   = $urandom;
        out_ready = ($urandom_range(0, 9) < pr);
        step();
      end
    end
    drain();

    // Flush with three beats held and a marker beat offered.
    fill(3, 32'h5000);
    check_eq("pre_flush_occ", 32'(occupancy), 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_data = marker;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_out_valid", 32'(out_valid), 32'd0);
    check_eq("flush_occ", 32'(occupancy), 32'd0);
    out_ready = 1'b1;
    acc_count = 0;
    for (int i = 0; i < 12 && acc_count < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h5100 + acc_count;
      step();
    end
    drain();
    check_eq("flush_marker_seen", marker_seen, 32'd0);

    // Reset mid-stream with four beats held, then a clean stream.
    fill(4, 32'h6000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mid_rst_occ", 32'(occupancy), 32'd0);
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_out_data", out_data, RV2);
    out_ready = 1'b1;
    acc_count = 0;
    for (int i = 0; i < 30 && acc_count < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + acc_count;
      step();
    end
    check_eq("post_rst_accepted", acc_count, 32'd8);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
